// File: rtl/tail_light_pkg.sv
// Shared tail-light types: lamp modes, per-phase lamp patterns, phase width.
// Define SEQ_HOLD_EN to add a held all-on phase (5-step sweep instead of 4).
package tail_light_pkg;

  typedef enum logic [1:0] {NONE, LEFT, RIGHT, HAZ} mode_t;

`ifdef SEQ_HOLD_EN
  localparam int PH_W = 3;
  localparam logic [PH_W-1:0] PH_LAST = 3'd4;
`else
  localparam int PH_W = 2;
  localparam logic [PH_W-1:0] PH_LAST = 2'd3;
`endif

  // Indexed by phase; entry 4 is only reachable in the hold build.
  localparam logic [4:0][2:0] LEFT_PAT  = {3'b111, 3'b111, 3'b011, 3'b001, 3'b000};
  localparam logic [4:0][2:0] RIGHT_PAT = {3'b111, 3'b111, 3'b110, 3'b100, 3'b000};
  localparam logic [5:0]      HAZ_ON    = 6'b111111;
  localparam logic [5:0]      HAZ_OFF   = 6'b000000;

  function automatic logic [PH_W-1:0] next_ph(input logic [PH_W-1:0] ph);
    return (ph == PH_LAST) ? '0 : ph + 1'b1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..DIV_MAX divider with sync clear and enable; tc marks the
// terminal-count cycle and is suppressed while clear is asserted.
module tick_prescaler #(
  parameter int DIV_W   = 24,
  parameter int DIV_MAX = 12_499_999
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [DIV_W-1:0] div;

  assign tc = en & ~clr & (div == DIV_W'(DIV_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      div <= '0;
    else if (clr) div <= '0;
    else if (en)  div <= tc ? '0 : div + 1'b1;
  end

endmodule

// File: rtl/turn_sequencer.sv
// Turn/hazard lamp animator: decodes the main FSM mode flags (H > L > R) and
// steps a sweep phase / hazard flash on each prescaler tick. Build option: SEQ_HOLD_EN.
module turn_sequencer
  import tail_light_pkg::*;
#(
  parameter int DIV_W   = 24,
  parameter int DIV_MAX = 12_499_999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       L,
  input  logic       H,
  input  logic       R,
  output logic [2:0] left_out,
  output logic [2:0] right_out,
  output logic [5:0] haz_out,
  output logic       step
);

  mode_t            mode_d, mode_q;
  logic             chg, tc;
  logic [PH_W-1:0]  ph;
  logic [2:0]       ph_x;
  logic             haz_q;

  always_comb begin
    mode_d = NONE;
    if (H)      mode_d = HAZ;
    else if (L) mode_d = LEFT;
    else if (R) mode_d = RIGHT;
  end

  assign chg  = (mode_d != mode_q);
  assign step = tc;

  // Any mode change restarts the step period, so a new pattern gets a full first step.
  tick_prescaler #(.DIV_W(DIV_W), .DIV_MAX(DIV_MAX)) u_presc (
    .clk (clk),
    .rst (rst),
    .clr (chg | (mode_q == NONE)),
    .en  (mode_q != NONE),
    .tc  (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= NONE;
      ph     <= '0;
      haz_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      if (chg) begin
        ph    <= (mode_d == NONE) ? '0 : PH_W'(1);
        haz_q <= (mode_d != NONE);
      end else if (tc) begin
        ph    <= next_ph(ph);
        haz_q <= ~haz_q;
      end
    end
  end

  assign ph_x = 3'(ph);

  always_comb begin
    left_out  = 3'b000;
    right_out = 3'b000;
    haz_out   = HAZ_OFF;
    case (mode_q)
      LEFT:    left_out  = LEFT_PAT[ph_x];
      RIGHT:   right_out = RIGHT_PAT[ph_x];
      HAZ:     haz_out   = haz_q ? HAZ_ON : HAZ_OFF;
      default: ;
    endcase
  end

endmodule
